// File: rtl/chess_turn_controller.sv
// Two-player chess clock sequencer: owns the turn FSM and the timer tick prescaler,
// and arbitrates timeout, surrender and turn-switch events into a latched result.
module chess_turn_controller #(
   parameter int unsigned TICK_DIV   = 100000000,
   parameter int unsigned MOVE_CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  switch_turn,
   input  logic                  surrender_player1,
   input  logic                  surrender_player2,
   input  logic                  p1_timeout,
   input  logic                  p2_timeout,
   output logic                  load_timers,
   output logic                  tick_p1,
   output logic                  tick_p2,
   output logic                  player_turn,
   output logic                  game_over,
   output logic [MOVE_CNT_W-1:0] move_count,
   output logic                  player1_green_led,
   output logic                  player2_green_led,
   output logic                  player1_red_led,
   output logic                  player2_red_led
);

   localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, OVER} state_e;

   state_e                state_q, state_d;
   logic [PRESC_W-1:0]    presc_q, presc_d;
   logic                  start_q, switch_q, sur1_q, sur2_q;
   logic                  load_q, load_d;
   logic                  tick1_q, tick1_d, tick2_q, tick2_d;
   logic                  turn_q, turn_d;
   logic                  over_q, over_d;
   logic [MOVE_CNT_W-1:0] cnt_q, cnt_d;
   logic                  g1_q, g1_d, g2_q, g2_d, r1_q, r1_d, r2_q, r2_d;

   logic start_rise_c, switch_rise_c, sur1_rise_c, sur2_rise_c;
   logic p1_loses_c;

   assign start_rise_c  = start & ~start_q;
   assign switch_rise_c = switch_turn & ~switch_q;
   assign sur1_rise_c   = surrender_player1 & ~sur1_q;
   assign sur2_rise_c   = surrender_player2 & ~sur2_q;

   // Next-state, prescaler and result arbitration
   always_comb begin
      state_d    = state_q;
      presc_d    = presc_q;
      load_d     = 1'b0;
      tick1_d    = 1'b0;
      tick2_d    = 1'b0;
      turn_d     = turn_q;
      over_d     = over_q;
      cnt_d      = cnt_q;
      g1_d       = g1_q;
      g2_d       = g2_q;
      r1_d       = r1_q;
      r2_d       = r2_q;
      p1_loses_c = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_rise_c) begin
               load_d  = 1'b1;
               turn_d  = 1'b0;
               presc_d = '0;
               state_d = RUN;
            end
         end
         RUN, PAUSE: begin
            if (p1_timeout || p2_timeout) begin
               // Double timeout is charged to the player on move
               p1_loses_c = (p1_timeout && p2_timeout) ? ~turn_q : p1_timeout;
               r1_d    = p1_loses_c;
               g2_d    = p1_loses_c;
               r2_d    = ~p1_loses_c;
               g1_d    = ~p1_loses_c;
               over_d  = 1'b1;
               state_d = OVER;
            end else if (sur1_rise_c || sur2_rise_c) begin
               r1_d    = sur1_rise_c;
               r2_d    = sur2_rise_c;
               g1_d    = ~sur1_rise_c;
               g2_d    = ~sur2_rise_c;
               over_d  = 1'b1;
               state_d = OVER;
            end else if (state_q == RUN) begin
               if (!start) begin
                  state_d = PAUSE;
               end else if (switch_rise_c) begin
                  turn_d  = ~turn_q;
                  presc_d = '0;
                  if (cnt_q != '1) cnt_d = cnt_q + MOVE_CNT_W'(1);
               end else if (!load_q) begin
                  // Prescaler holds during the timer-load cycle
                  if (presc_q == PRESC_LAST) begin
                     presc_d = '0;
                     tick1_d = ~turn_q;
                     tick2_d = turn_q;
                  end else begin
                     presc_d = presc_q + PRESC_W'(1);
                  end
               end
            end else if (start) begin
               state_d = RUN;
            end
         end
         OVER: begin
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         presc_q  <= '0;
         start_q  <= 1'b0;
         switch_q <= 1'b0;
         sur1_q   <= 1'b0;
         sur2_q   <= 1'b0;
         load_q   <= 1'b0;
         tick1_q  <= 1'b0;
         tick2_q  <= 1'b0;
         turn_q   <= 1'b0;
         over_q   <= 1'b0;
         cnt_q    <= '0;
         g1_q     <= 1'b0;
         g2_q     <= 1'b0;
         r1_q     <= 1'b0;
         r2_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         presc_q  <= presc_d;
         start_q  <= start;
         switch_q <= switch_turn;
         sur1_q   <= surrender_player1;
         sur2_q   <= surrender_player2;
         load_q   <= load_d;
         tick1_q  <= tick1_d;
         tick2_q  <= tick2_d;
         turn_q   <= turn_d;
         over_q   <= over_d;
         cnt_q    <= cnt_d;
         g1_q     <= g1_d;
         g2_q     <= g2_d;
         r1_q     <= r1_d;
         r2_q     <= r2_d;
      end
   end

   assign load_timers       = load_q;
   assign tick_p1           = tick1_q;
   assign tick_p2           = tick2_q;
   assign player_turn       = turn_q;
   assign game_over         = over_q;
   assign move_count        = cnt_q;
   assign player1_green_led = g1_q;
   assign player2_green_led = g2_q;
   assign player1_red_led   = r1_q;
   assign player2_red_led   = r2_q;

endmodule

// File: tb/tb_chess_turn_controller.sv
// Directed bench for chess_turn_controller with TICK_DIV=4.
module tb_chess_turn_controller;

   logic       clk = 1'b0;
   logic       reset, start, switch_turn, surrender_player1, surrender_player2;
   logic       p1_timeout, p2_timeout;
   logic       load_timers, tick_p1, tick_p2, player_turn, game_over;
   logic [7:0] move_count;
   logic       player1_green_led, player2_green_led, player1_red_led, player2_red_led;

   int total = 0;
   int bad   = 0;

   logic [16:0] outv;
   logic [3:0]  leds;
   assign leds = {player1_green_led, player2_green_led, player1_red_led, player2_red_led};
   assign outv = {load_timers, tick_p1, tick_p2, player_turn, game_over, move_count, leds};

   chess_turn_controller #(.TICK_DIV(4), .MOVE_CNT_W(8)) dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .switch_turn       (switch_turn),
      .surrender_player1 (surrender_player1),
      .surrender_player2 (surrender_player2),
      .p1_timeout        (p1_timeout),
      .p2_timeout        (p2_timeout),
      .load_timers       (load_timers),
      .tick_p1           (tick_p1),
      .tick_p2           (tick_p2),
      .player_turn       (player_turn),
      .game_over         (game_over),
      .move_count        (move_count),
      .player1_green_led (player1_green_led),
      .player2_green_led (player2_green_led),
      .player1_red_led   (player1_red_led),
      .player2_red_led   (player2_red_led)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      start = 1'b0; switch_turn = 1'b0;
      surrender_player1 = 1'b0; surrender_player2 = 1'b0;
      p1_timeout = 1'b0; p2_timeout = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      clear_inputs();
      step();
      step();
      reset = 1'b1;
   endtask

   initial begin
      // 1: reset, then idle with start low
      do_reset();
      step();
      chk("reset_outputs", 32'(outv), 32'd0);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("idle_quiet", 32'({load_timers, tick_p1, tick_p2}), 32'd0);
      end

      // 2: start edge loads timers, player 1 ticks at +5, +9, +13
      start = 1'b1;
      step();
      chk("load_pulse", 32'(load_timers), 32'd1);
      for (int i = 1; i <= 14; i++) begin
         step();
         chk("run_p1_ticks", 32'({load_timers, tick_p1, tick_p2}),
             (i == 5 || i == 9 || i == 13) ? 32'b010 : 32'b000);
      end

      // 3: held switch_turn gives one move; player 2 ticks at +4, +8
      switch_turn = 1'b1;
      step();
      chk("turn_after_switch", 32'(player_turn), 32'd1);
      chk("count_after_switch", 32'(move_count), 32'd1);
      for (int i = 1; i <= 10; i++) begin
         step();
         chk("run_p2_ticks", 32'({tick_p1, tick_p2}),
             (i == 4 || i == 8) ? 32'b01 : 32'b00);
      end
      switch_turn = 1'b0;
      chk("held_switch_single", 32'({player_turn, move_count}), 32'h101);

      // 4: pause with prescaler at 2, resume finishes the remaining count
      start = 1'b0;
      step();
      for (int i = 0; i < 20; i++) begin
         step();
         chk("pause_no_tick", 32'({tick_p1, tick_p2}), 32'd0);
      end
      start = 1'b1;
      step();
      chk("resume_edge", 32'({tick_p1, tick_p2}), 32'd0);
      for (int i = 1; i <= 6; i++) begin
         step();
         chk("resume_ticks", 32'({tick_p1, tick_p2}),
             (i == 2 || i == 6) ? 32'b01 : 32'b00);
      end

      // 5: timeout beats surrender and switch in the same cycle
      p2_timeout = 1'b1; surrender_player2 = 1'b1; switch_turn = 1'b1;
      step();
      chk("timeout_priority", 32'(outv), 32'({5'b00011, 8'd1, 4'b1001}));
      p2_timeout = 1'b0; surrender_player2 = 1'b0; switch_turn = 1'b0;
      step();
      switch_turn = 1'b1; surrender_player1 = 1'b1;
      step();
      step();
      chk("over_frozen", 32'(outv), 32'({5'b00011, 8'd1, 4'b1001}));

      // Double timeout: player on move (player 1) loses
      do_reset();
      start = 1'b1;
      step();
      step();
      p1_timeout = 1'b1; p2_timeout = 1'b1;
      step();
      chk("double_timeout", 32'(outv), 32'({5'b00001, 8'd0, 4'b0110}));

      // 6: simultaneous surrender is a draw, then reset clears everything
      do_reset();
      start = 1'b1;
      step();
      step();
      surrender_player1 = 1'b1; surrender_player2 = 1'b1;
      step();
      chk("draw_result", 32'(outv), 32'({5'b00001, 8'd0, 4'b0011}));
      reset = 1'b0;
      step();
      chk("reset_mid_over", 32'(outv), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
